// File: rtl/uart_transmitter_if.sv
// -----------------------------------------------------------------------------
// uart_transmitter_if
// Byte-producer / serial-line bundle for uart_transmitter.
//   data     [7:0]  byte to enqueue (producer -> transmitter)
//   send            enqueue strobe (producer -> transmitter)
//   tx              serial line, idles high
//   busy            frame (start .. end of idle gap) in progress
//   full / empty    registered FIFO status flags
//   done            one-cycle pulse on the last clk of each stop bit
//   overflow        one-cycle pulse after a send that arrived while full
// master = byte producer, slave = transmitter.
// -----------------------------------------------------------------------------
interface uart_transmitter_if;
   logic [7:0] data;
   logic       send;
   logic       tx;
   logic       busy;
   logic       full;
   logic       empty;
   logic       done;
   logic       overflow;

   modport master (
      output data, send,
      input  tx, busy, full, empty, done, overflow
   );

   modport slave (
      input  data, send,
      output tx, busy, full, empty, done, overflow
   );
endinterface

// File: rtl/uart_transmitter.sv
// -----------------------------------------------------------------------------
// uart_transmitter
// FIFO-buffered UART transmitter. Frame: start(0), 8 data bits LSB first,
// even parity, stop(1), then IDLE_BITS forced idle-high bit periods.
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous active-high reset; aborts any frame, flushes FIFO
//   bus    uart_transmitter_if.slave (data/send in; tx/busy/full/empty/
//          done/overflow out, all registered)
// Parameters:
//   CLKS_PER_BIT  clk cycles per serial bit (>= 1)
//   FIFO_DEPTH    byte FIFO entries (power of 2, >= 2)
//   IDLE_BITS     idle-high bit periods after each stop bit (>= 1)
// -----------------------------------------------------------------------------
module uart_transmitter #(
   parameter int CLKS_PER_BIT = 1,
   parameter int FIFO_DEPTH   = 4,
   parameter int IDLE_BITS    = 2
) (
   input  logic              clk,
   input  logic              reset,
   uart_transmitter_if.slave bus
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int PW = AW + 1;
   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   // Bit counter serves both the data index (0..7) and the gap period count.
   localparam int BW = (IDLE_BITS > 8) ? $clog2(IDLE_BITS) : 3;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP,
      S_GAP
   } state_t;

   // ---------------- FIFO ----------------
   logic [7:0]    mem_q [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] count_q, count_d;
   logic          full_q, empty_q, overflow_q;
   logic          push, pop;

   // ---------------- FSM ----------------
   state_t        state_q, state_d;
   logic [CW-1:0] baud_q, baud_d;
   logic [BW-1:0] bit_q, bit_d;
   logic [7:0]    shift_q, shift_d;
   logic          parity_q, parity_d;
   logic          tx_q, tx_d;
   logic          busy_q;
   logic          done_q, done_d;
   logic          period_end;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   // full_q is the pre-edge value, so a push while full is rejected even if
   // the FSM pops in the same cycle.
   assign push = bus.send && !full_q;
   assign pop  = (state_q == S_IDLE) && !empty_q;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         wr_ptr_d = ptr_inc(wr_ptr_q);
      end
      if (pop) begin
         rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      case ({push, pop})
         2'b10:   count_d = count_q + PW'(1);
         2'b01:   count_d = count_q - PW'(1);
         default: count_d = count_q;
      endcase
   end

   // Storage is not reset; pointers/count define which entries are valid.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q[AW-1:0]] <= bus.data;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         full_q     <= 1'b0;
         empty_q    <= 1'b1;
         overflow_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         full_q     <= (count_d == PW'(FIFO_DEPTH));
         empty_q    <= (count_d == '0);
         overflow_q <= bus.send && full_q;
      end
   end

   // ---------------- FSM next state ----------------
   assign period_end = (baud_q == CW'(CLKS_PER_BIT - 1));

   always_comb begin
      state_d  = state_q;
      baud_d   = baud_q;
      bit_d    = bit_q;
      shift_d  = shift_q;
      parity_d = parity_q;
      tx_d     = 1'b1;
      done_d   = 1'b0;

      if (state_q != S_IDLE) begin
         baud_d = period_end ? '0 : baud_q + CW'(1);
      end

      case (state_q)
         S_IDLE: begin
            baud_d = '0;
            bit_d  = '0;
            if (pop) begin
               // Byte leaves the FIFO here, so later writes cannot disturb it.
               shift_d  = mem_q[rd_ptr_q[AW-1:0]];
               parity_d = ^mem_q[rd_ptr_q[AW-1:0]];
               state_d  = S_START;
            end
         end
         S_START: begin
            if (period_end) begin
               state_d = S_DATA;
               bit_d   = '0;
            end
         end
         S_DATA: begin
            if (period_end) begin
               if (bit_q == BW'(7)) begin
                  state_d = S_PARITY;
                  bit_d   = '0;
               end else begin
                  bit_d = bit_q + BW'(1);
               end
            end
         end
         S_PARITY: begin
            if (period_end) begin
               state_d = S_STOP;
            end
         end
         S_STOP: begin
            if (period_end) begin
               state_d = S_GAP;
               bit_d   = '0;
            end
         end
         S_GAP: begin
            if (period_end) begin
               if (bit_q == BW'(IDLE_BITS - 1)) begin
                  state_d = S_IDLE;
                  bit_d   = '0;
               end else begin
                  bit_d = bit_q + BW'(1);
               end
            end
         end
         default: begin
            state_d = S_IDLE;
            baud_d  = '0;
            bit_d   = '0;
         end
      endcase

      // Outputs are registered from next-state values so tx/busy/done line up
      // with state_q without any combinational path from the producer side.
      case (state_d)
         S_START:  tx_d = 1'b0;
         S_DATA:   tx_d = shift_d[bit_d[2:0]];
         S_PARITY: tx_d = parity_d;
         default:  tx_d = 1'b1;
      endcase
      done_d = (state_d == S_STOP) && (baud_d == CW'(CLKS_PER_BIT - 1));
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         baud_q   <= '0;
         bit_q    <= '0;
         shift_q  <= '0;
         parity_q <= 1'b0;
         tx_q     <= 1'b1;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         baud_q   <= baud_d;
         bit_q    <= bit_d;
         shift_q  <= shift_d;
         parity_q <= parity_d;
         tx_q     <= tx_d;
         busy_q   <= (state_d != S_IDLE);
         done_q   <= done_d;
      end
   end

   assign bus.tx       = tx_q;
   assign bus.busy     = busy_q;
   assign bus.full     = full_q;
   assign bus.empty    = empty_q;
   assign bus.done     = done_q;
   assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// -----------------------------------------------------------------------------
// tb_uart_transmitter
// Directed bench for uart_transmitter. u1 runs the one-bit-per-clock link
// (CLKS_PER_BIT=1), u4 the slow link (CLKS_PER_BIT=4). A line monitor decodes
// u1's tx into a byte queue with start-cycle stamps.
// -----------------------------------------------------------------------------
module tb_uart_transmitter;

   logic clk;
   logic reset;
   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;

   uart_transmitter_if if1 ();
   uart_transmitter_if if4 ();

   uart_transmitter #(.CLKS_PER_BIT(1), .FIFO_DEPTH(4), .IDLE_BITS(2)) u1 (
      .clk   (clk),
      .reset (reset),
      .bus   (if1)
   );

   uart_transmitter #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4), .IDLE_BITS(2)) u4 (
      .clk   (clk),
      .reset (reset),
      .bus   (if4)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic put1(input logic [7:0] b);
      if1.data = b;
      if1.send = 1'b1;
      step();
      if1.send = 1'b0;
      $display("write byte=%02h cycle=%0d full=%0b", b, cyc, if1.full);
   endtask

   task automatic wait_idle1(input string tag);
      int n;
      n = 0;
      while (!(if1.busy == 1'b0 && if1.empty == 1'b1) && n < 400) begin
         step();
         n++;
      end
      check(tag, 32'(n < 400), 32'd1);
   endtask

   // ---------------- line monitor on u1 ----------------
   logic [7:0] m_q[$];
   int         m_start_t[$];

   initial begin : monitor
      int         pos;
      logic [9:0] sh;
      pos = -1;
      sh  = '0;
      forever begin
         @(posedge clk);
         #1;
         if (reset) begin
            pos = -1;
         end else if (pos < 0) begin
            if (if1.tx == 1'b0) begin
               pos = 0;
               m_start_t.push_back(cyc);
            end
         end else begin
            sh[pos] = if1.tx;
            pos++;
            if (pos == 10) begin
               check("mon_parity", 32'(sh[8]), 32'(^sh[7:0]));
               check("mon_stop", 32'(sh[9]), 32'd1);
               m_q.push_back(sh[7:0]);
               $display("line byte=%02h parity=%0b start_cycle=%0d", sh[7:0], sh[8],
                        m_start_t[m_start_t.size()-1]);
               pos = -1;
            end
         end
      end
   end

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   logic [14:0] seq;
   logic        t4 [0:56];
   logic [10:0] frame4;
   logic [3:0]  v4;
   logic [7:0]  bytes3 [0:5];
   int          bcnt, dcnt, dpos, lowcnt, ovcnt;

   initial begin
      reset    = 1'b0;
      if1.data = '0;
      if1.send = 1'b0;
      if4.data = '0;
      if4.send = 1'b0;

      // Reset takes effect without a clock edge.
      #1 reset = 1'b1;
      #2;
      check("rst_tx", 32'(if1.tx), 32'd1);
      check("rst_busy", 32'(if1.busy), 32'd0);
      check("rst_full", 32'(if1.full), 32'd0);
      check("rst_empty", 32'(if1.empty), 32'd1);
      check("rst_done", 32'(if1.done), 32'd0);
      check("rst_overflow", 32'(if1.overflow), 32'd0);
      check("rst_tx4", 32'(if4.tx), 32'd1);
      step();
      step();
      reset = 1'b0;
      step();

      // ---- Test 1: 0xA5, one bit per clk ----
      seq  = '0;
      bcnt = 0;
      dcnt = 0;
      dpos = -1;
      put1(8'hA5);
      seq[0] = if1.tx;
      if (if1.busy) bcnt++;
      for (int k = 1; k <= 14; k++) begin
         step();
         seq[k] = if1.tx;
         if (if1.busy) bcnt++;
         if (if1.done) begin
            dcnt++;
            dpos = k;
         end
      end
      // k=0..13: idle,start,1,0,1,0,0,1,0,1,parity 0,stop,gap,gap
      check("t1_tx_seq", 32'(seq[13:0]), 32'(14'b11101010010101));
      check("t1_busy_clks", bcnt, 13);
      check("t1_done_cnt", dcnt, 1);
      check("t1_done_pos", dpos, 11);
      check("t1_busy_end", 32'(if1.busy), 32'd0);
      step();
      m_q.delete();
      m_start_t.delete();

      // ---- Test 2: 0x07 with CLKS_PER_BIT=4, parity 1 ----
      frame4 = {1'b1, 1'b1, 8'h07, 1'b0};
      bcnt = 0;
      dcnt = 0;
      dpos = -1;
      if4.data = 8'h07;
      if4.send = 1'b1;
      step();
      if4.send = 1'b0;
      $display("write4 byte=07 cycle=%0d", cyc);
      t4[0] = if4.tx;
      for (int k = 1; k <= 56; k++) begin
         step();
         t4[k] = if4.tx;
         if (if4.busy) bcnt++;
         if (if4.done) begin
            dcnt++;
            dpos = k;
         end
      end
      for (int b = 0; b < 11; b++) begin
         v4 = {t4[4*b+1], t4[4*b+2], t4[4*b+3], t4[4*b+4]};
         check($sformatf("t2_bit%0d", b), 32'(v4), frame4[b] ? 32'hF : 32'h0);
      end
      check("t2_busy_clks", bcnt, 52);
      check("t2_done_cnt", dcnt, 1);
      check("t2_done_pos", dpos, 44);
      check("t2_tx_after", 32'(t4[56]), 32'd1);

      // ---- Test 3: six consecutive writes into a depth-4 FIFO ----
      bytes3[0] = 8'h11; bytes3[1] = 8'h22; bytes3[2] = 8'h33;
      bytes3[3] = 8'h44; bytes3[4] = 8'h55; bytes3[5] = 8'h66;
      m_q.delete();
      ovcnt = 0;
      for (int i = 0; i < 6; i++) begin
         put1(bytes3[i]);
         check($sformatf("t3_full_w%0d", i), 32'(if1.full), (i >= 4) ? 32'd1 : 32'd0);
         check($sformatf("t3_ovf_w%0d", i), 32'(if1.overflow), (i == 5) ? 32'd1 : 32'd0);
         if (if1.overflow) ovcnt++;
      end
      step();
      if (if1.overflow) ovcnt++;
      check("t3_ovf_cnt", ovcnt, 1);
      wait_idle1("t3_drain");
      check("t3_rx_count", m_q.size(), 5);
      for (int i = 0; i < 5; i++) begin
         if (i < m_q.size()) check($sformatf("t3_rx%0d", i), 32'(m_q[i]), 32'(bytes3[i]));
      end

      // ---- Test 4: 00, FF, 55 back-to-back, spacing 14 ----
      m_q.delete();
      m_start_t.delete();
      put1(8'h00);
      put1(8'hFF);
      put1(8'h55);
      wait_idle1("t4_drain");
      check("t4_rx_count", m_q.size(), 3);
      if (m_q.size() >= 3 && m_start_t.size() >= 3) begin
         check("t4_rx0", 32'(m_q[0]), 32'h00);
         check("t4_rx1", 32'(m_q[1]), 32'hFF);
         check("t4_rx2", 32'(m_q[2]), 32'h55);
         check("t4_space01", m_start_t[1] - m_start_t[0], 14);
         check("t4_space12", m_start_t[2] - m_start_t[1], 14);
      end

      // ---- Test 5: reset during DATA of the second of three bytes ----
      m_q.delete();
      put1(8'h81);
      put1(8'h42);
      put1(8'h24);
      repeat (16) step();
      // second frame: data bit 2 of 0x42 is on the line now
      check("t5_busy_pre", 32'(if1.busy), 32'd1);
      check("t5_tx_pre", 32'(if1.tx), 32'd0);
      #2 reset = 1'b1;
      #1;
      check("t5_tx", 32'(if1.tx), 32'd1);
      check("t5_empty", 32'(if1.empty), 32'd1);
      check("t5_busy", 32'(if1.busy), 32'd0);
      check("t5_full", 32'(if1.full), 32'd0);
      step();
      step();
      reset = 1'b0;
      lowcnt = 0;
      for (int k = 0; k < 40; k++) begin
         step();
         if (if1.tx == 1'b0) lowcnt++;
      end
      check("t5_quiet", lowcnt, 0);
      check("t5_rx_count", m_q.size(), 1);
      if (m_q.size() >= 1) check("t5_rx0", 32'(m_q[0]), 32'h81);
      put1(8'h3C);
      wait_idle1("t5_drain");
      check("t5_rx_count2", m_q.size(), 2);
      if (m_q.size() >= 2) check("t5_rx1", 32'(m_q[1]), 32'h3C);

      // ---- Test 6: push and pop together at count = DEPTH-1 ----
      m_q.delete();
      put1(8'hA1);
      put1(8'hB2);
      put1(8'hC3);
      put1(8'hD4);
      check("t6_count_pre", 32'(u1.count_q), 32'd3);
      check("t6_full_pre", 32'(if1.full), 32'd0);
      repeat (11) step();
      check("t6_idle_busy", 32'(if1.busy), 32'd0);
      check("t6_idle_empty", 32'(if1.empty), 32'd0);
      put1(8'hE5);
      check("t6_count_post", 32'(u1.count_q), 32'd3);
      check("t6_full_post", 32'(if1.full), 32'd0);
      check("t6_start", 32'(if1.tx), 32'd0);
      wait_idle1("t6_drain");
      check("t6_rx_count", m_q.size(), 5);
      if (m_q.size() >= 5) begin
         check("t6_rx0", 32'(m_q[0]), 32'hA1);
         check("t6_rx1", 32'(m_q[1]), 32'hB2);
         check("t6_rx2", 32'(m_q[2]), 32'hC3);
         check("t6_rx3", 32'(m_q[3]), 32'hD4);
         check("t6_rx4", 32'(m_q[4]), 32'hE5);
      end

      step();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/uart_transmitter.md
Name: uart_transmitter

Overview:
Serialises bytes onto a single-wire UART line for the team's FPGA link. Frame format is start (0), 8 data bits LSB first, even parity bit (XOR of the 8 data bits), stop (1). This is the format the existing on-chip UART receiver decodes. A small FIFO decouples the byte producer from line timing. A baud divider allows the same block to drive both the one-bit-per-clock internal link and slower external links.

Parameters:
CLKS_PER_BIT, 1, clk cycles per serial bit period; must be >= 1.
FIFO_DEPTH, 4, byte FIFO entries; must be a power of 2 and >= 2.
IDLE_BITS, 2, number of idle-high bit periods forced after each stop bit before the next start bit; must be >= 1. Minimum 2 when feeding the receiver, which needs its post-stop cycles.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-high reset.
data  input  8  byte to enqueue; sampled when send=1 and full=0.
send  input  1  enqueue strobe; one byte accepted per cycle in which send=1 and full=0.
tx  output  1  serial line; idles high.
busy  output  1  1 from the start bit through the end of the last IDLE_BITS period.
full  output  1  FIFO holds FIFO_DEPTH bytes; send is ignored while full=1.
empty  output  1  FIFO holds no bytes.
done  output  1  single-cycle pulse on the last clk of each stop bit period.
overflow  output  1  single-cycle pulse the cycle after send=1 arrives while full=1; that byte is dropped.

Behaviour:
- Reset (asynchronous, applied immediately): tx=1, busy=0, full=0, empty=1, done=0, overflow=0. FIFO pointers and count cleared, FSM in IDLE, baud and bit counters at 0. Reset mid-frame aborts the frame, drives tx high at once, and flushes the FIFO.
- FIFO: write pointer, read pointer, and count are each sized log2(FIFO_DEPTH)+1 bits. Pointers wrap modulo FIFO_DEPTH. full and empty are registered and derived from count.
- Push and pop in the same cycle:
  - Both take effect and count is unchanged.
  - When full=1, the push is rejected even if a pop occurs that cycle, because full is evaluated before the edge.
  - When empty=1, no pop is possible, so a push is the only effect.
- FSM states: IDLE, START, DATA, PARITY, STOP, GAP. Each non-IDLE state lasts exactly CLKS_PER_BIT clks, timed by the baud counter, which counts 0..CLKS_PER_BIT-1.
  - IDLE: tx=1, busy=0. If empty=0 at an edge: pop the head into the shift register, latch parity = XOR of the byte, go to START.
  - START: tx=0, busy=1. At end of period go to DATA with bit index 0.
  - DATA: tx = shift[index], LSB first. At end of period: if index=7 go to PARITY, else index+1.
  - PARITY: tx = latched parity. At end of period go to STOP.
  - STOP: tx=1. done pulses on the final clk of this period. At end of period go to GAP.
  - GAP: tx=1, busy=1 for IDLE_BITS*CLKS_PER_BIT clks, then go to IDLE.
- tx is a registered output with no combinational path from data or send.
- Latency: byte written at edge N with FIFO empty and FSM in IDLE gives tx=0 (start bit) after edge N+1.
- Frame length is 11*CLKS_PER_BIT clks. Back-to-back bytes have a start-to-start spacing of (11+IDLE_BITS)*CLKS_PER_BIT+1 clks; the +1 is the IDLE cycle.
- A byte in flight is held in the shift register, so writes during a frame never corrupt it.

Test Plan:
1. Reset, CLKS_PER_BIT=1: write 0xA5 (parity 0) -> tx reads 1,0,1,0,1,0,0,1,0,1,0,1 across idle, start, bits LSB first, parity, stop. busy=1 for 13 clks. done pulses once on the stop clk.
2. Write 0x07 (parity 1) with CLKS_PER_BIT=4 -> every bit is held 4 clks and the parity bit is 1. Loopback into the existing receiver yields data=0x07, error=0, sent=1.
3. Write 5 bytes on consecutive clks with FIFO_DEPTH=4 and the first byte popped at clk 2 -> all 5 accepted, full toggles as expected, no overflow. Six rapid writes -> exactly one overflow pulse, and the dropped byte never appears on tx.
4. Stream 0x00, 0xFF, 0x55 back-to-back -> start-to-start spacing is 14 clks with IDLE_BITS=2, CLKS_PER_BIT=1. The receiver loopback returns all three bytes with error=0.
5. Assert reset during DATA of the second byte of three queued -> tx=1 immediately, empty=1, busy=0. Nothing more is transmitted until a new write.
6. Simultaneous send and pop in the same cycle while count=FIFO_DEPTH-1 -> count is unchanged, full stays 0, and both bytes are later transmitted in order.
